// File: rtl/spi_slave_param.sv
// SPI slave with a 2-bit command header followed by a DATA_WIDTH payload.
// Command 0x -> write frame, 1x -> read-address or read-data frame, chosen
// by whether a read address has already been received. A read-data frame
// waits for tx_data and then returns it on miso.
// Optional feature: define SPI_SLAVE_ERR_CNT_EN to add the 8-bit err_cnt
// output, a saturating count of frame_err pulses.
module spi_slave_param #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ss_n,
    input  logic                    mosi,
    output logic                    miso,
    output logic [DATA_WIDTH+1:0]   rx_data,
    output logic                    rx_valid,
    input  logic [DATA_WIDTH-1:0]   tx_data,
    input  logic                    tx_valid,
    output logic                    busy,
`ifdef SPI_SLAVE_ERR_CNT_EN
    output logic                    frame_err,
    output logic [7:0]              err_cnt
`else
    output logic                    frame_err
`endif
);

    localparam int FW = DATA_WIDTH + 2;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    // Progress inside a frame state: receiving, waiting for read data,
    // returning read data, or finished and holding until ss_n rises.
    typedef enum logic [1:0] {
        PH_RX,
        PH_WAIT,
        PH_TX,
        PH_HOLD
    } phase_e;

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [CW-1:0]         bitCnt_q, bitCnt_d;
    logic                  cmdHi_q, cmdHi_d;
    logic                  cmdLo_q, cmdLo_d;
    logic [DATA_WIDTH-1:0] rxShift_q, rxShift_d;
    logic [FW-1:0]         rxData_q, rxData_d;
    logic                  rxValid_q, rxValid_d;
    logic [DATA_WIDTH-1:0] txShift_q, txShift_d;
    logic [CW-1:0]         txLeft_q, txLeft_d;
    logic                  miso_q, miso_d;
    logic                  frameErr_q, frameErr_d;
    logic                  rdAddrSeen_q, rdAddrSeen_d;

    logic [DATA_WIDTH-1:0] rxShiftNext;
    logic                  txFirstBit;
    logic [DATA_WIDTH-1:0] txLoadShift;
    logic                  txNextBit;
    logic [DATA_WIDTH-1:0] txNextShift;

    // Bit-order dependent shifting for both directions.
    if (MSB_FIRST) begin : gMsbFirst
        assign rxShiftNext = {rxShift_q[DATA_WIDTH-2:0], mosi};
        assign txFirstBit  = tx_data[DATA_WIDTH-1];
        assign txLoadShift = {tx_data[DATA_WIDTH-2:0], 1'b0};
        assign txNextBit   = txShift_q[DATA_WIDTH-1];
        assign txNextShift = {txShift_q[DATA_WIDTH-2:0], 1'b0};
    end else begin : gLsbFirst
        assign rxShiftNext = {mosi, rxShift_q[DATA_WIDTH-1:1]};
        assign txFirstBit  = tx_data[0];
        assign txLoadShift = {1'b0, tx_data[DATA_WIDTH-1:1]};
        assign txNextBit   = txShift_q[0];
        assign txNextShift = {1'b0, txShift_q[DATA_WIDTH-1:1]};
    end

    // State and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= PH_RX;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Datapath registers: counters, shifters, outputs and the read-address flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitCnt_q     <= '0;
            cmdHi_q      <= 1'b0;
            cmdLo_q      <= 1'b0;
            rxShift_q    <= '0;
            rxData_q     <= '0;
            rxValid_q    <= 1'b0;
            txShift_q    <= '0;
            txLeft_q     <= '0;
            miso_q       <= 1'b0;
            frameErr_q   <= 1'b0;
            rdAddrSeen_q <= 1'b0;
        end else begin
            bitCnt_q     <= bitCnt_d;
            cmdHi_q      <= cmdHi_d;
            cmdLo_q      <= cmdLo_d;
            rxShift_q    <= rxShift_d;
            rxData_q     <= rxData_d;
            rxValid_q    <= rxValid_d;
            txShift_q    <= txShift_d;
            txLeft_q     <= txLeft_d;
            miso_q       <= miso_d;
            frameErr_q   <= frameErr_d;
            rdAddrSeen_q <= rdAddrSeen_d;
        end
    end

    // Next-state logic: frame sequencing, bit capture, read-data return and aborts.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bitCnt_d     = bitCnt_q;
        cmdHi_d      = cmdHi_q;
        cmdLo_d      = cmdLo_q;
        rxShift_d    = rxShift_q;
        rxData_d     = rxData_q;
        rxValid_d    = 1'b0;
        txShift_d    = txShift_q;
        txLeft_d     = txLeft_q;
        miso_d       = 1'b0;
        frameErr_d   = 1'b0;
        rdAddrSeen_d = rdAddrSeen_q;

        case (state_q)
            IDLE: begin
                if (!ss_n) begin
                    state_d   = CHK_CMD;
                    phase_d   = PH_RX;
                    bitCnt_d  = '0;
                    rxShift_d = '0;
                    txShift_d = '0;
                    txLeft_d  = '0;
                end
            end

            CHK_CMD: begin
                if (ss_n) begin
                    state_d    = IDLE;
                    frameErr_d = 1'b1;
                end else begin
                    cmdHi_d = mosi;
                    if (!mosi) begin
                        state_d = WRITE;
                    end else if (rdAddrSeen_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
            end

            default: begin
                if (ss_n) begin
                    // Aborting is an error only while the frame still owes
                    // bits in either direction.
                    state_d = IDLE;
                    phase_d = PH_RX;
                    if ((phase_q == PH_RX) ||
                        ((phase_q == PH_TX) && (txLeft_q != '0))) begin
                        frameErr_d = 1'b1;
                    end
                end else begin
                    case (phase_q)
                        PH_RX: begin
                            bitCnt_d = bitCnt_q + CW'(1);
                            if (bitCnt_q == '0) begin
                                cmdLo_d = mosi;
                            end else begin
                                rxShift_d = rxShiftNext;
                            end
                            if (bitCnt_q == CW'(DATA_WIDTH)) begin
                                rxData_d  = {cmdHi_q, cmdLo_q, rxShiftNext};
                                rxValid_d = 1'b1;
                                if (state_q == READ_DATA) begin
                                    rdAddrSeen_d = 1'b0;
                                    phase_d      = PH_WAIT;
                                end else begin
                                    if (state_q == READ_ADD) begin
                                        rdAddrSeen_d = 1'b1;
                                    end
                                    phase_d = PH_HOLD;
                                end
                            end
                        end

                        PH_WAIT: begin
                            if (tx_valid) begin
                                miso_d    = txFirstBit;
                                txShift_d = txLoadShift;
                                txLeft_d  = CW'(DATA_WIDTH - 1);
                                phase_d   = PH_TX;
                            end
                        end

                        PH_TX: begin
                            if (txLeft_q == '0) begin
                                phase_d = PH_HOLD;
                            end else begin
                                miso_d    = txNextBit;
                                txShift_d = txNextShift;
                                txLeft_d  = txLeft_q - CW'(1);
                            end
                        end

                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

`ifdef SPI_SLAVE_ERR_CNT_EN
    logic [7:0] errCnt_q, errCnt_d;

    // Saturating count of aborted frames, stepped together with frame_err.
    always_comb begin
        errCnt_d = errCnt_q;
        if (frameErr_d && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCnt_q <= 8'd0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign err_cnt = errCnt_q;
`endif

    assign miso      = miso_q;
    assign rx_data   = rxData_q;
    assign rx_valid  = rxValid_q;
    assign frame_err = frameErr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param: a vector table of frames, random
// frames against a frame-level reference model, reset corner cases, and a
// 16-bit LSB-first instance.
module tb_spi_slave_param;

    localparam int DW  = 8;
    localparam int FW  = DW + 2;
    localparam bit MSB = 1'b1;

    logic          clk = 1'b0;
    logic          rstN;
    logic          ssN;
    logic          mosi;
    logic          miso;
    logic [FW-1:0] rxData;
    logic          rxValid;
    logic [DW-1:0] txData;
    logic          txValid;
    logic          busy;
    logic          frameErr;

    logic          ssN16;
    logic          mosi16;
    logic          miso16;
    logic [17:0]   rxData16;
    logic          rxValid16;
    logic [15:0]   txData16;
    logic          txValid16;
    logic          busy16;
    logic          frameErr16;

`ifdef SPI_SLAVE_ERR_CNT_EN
    logic [7:0]    errCnt;
    logic [7:0]    errCnt16;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    // Frame-level reference model state.
    bit            modelSeen;
    logic [FW-1:0] modelRx;
    int            modelErr;

    typedef struct {
        bit            c1;
        bit            c0;
        logic [DW-1:0] payload;
        int            abortAfter;
        logic [DW-1:0] txd;
        int            txCut;
        bit            cutRst;
        logic [FW-1:0] expRx;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_WIDTH(DW), .MSB_FIRST(MSB)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .ss_n      (ssN),
        .mosi      (mosi),
        .miso      (miso),
        .rx_data   (rxData),
        .rx_valid  (rxValid),
        .tx_data   (txData),
        .tx_valid  (txValid),
        .busy      (busy),
`ifdef SPI_SLAVE_ERR_CNT_EN
        .frame_err (frameErr),
        .err_cnt   (errCnt)
`else
        .frame_err (frameErr)
`endif
    );

    spi_slave_param #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) dut16 (
        .clk       (clk),
        .rst_n     (rstN),
        .ss_n      (ssN16),
        .mosi      (mosi16),
        .miso      (miso16),
        .rx_data   (rxData16),
        .rx_valid  (rxValid16),
        .tx_data   (txData16),
        .tx_valid  (txValid16),
        .busy      (busy16),
`ifdef SPI_SLAVE_ERR_CNT_EN
        .frame_err (frameErr16),
        .err_cnt   (errCnt16)
`else
        .frame_err (frameErr16)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset;
        modelSeen = 1'b0;
        modelRx   = '0;
        modelErr  = 0;
    endtask

    task automatic checkErrCnt;
`ifdef SPI_SLAVE_ERR_CNT_EN
        checkOutput("err_cnt", errCnt, modelErr);
`endif
    endtask

    // Runs one frame on the 8-bit instance and checks it against the model.
    // abortAfter >= 0 raises ss_n after that many mosi bits were sampled;
    // txCut >= 0 ends a read-data return after that many miso bits, by
    // ss_n (cutByReset=0) or by rst_n (cutByReset=1).
    task automatic applyStimulus(input bit c1, input bit c0, input logic [DW-1:0] payload,
                                 input int abortAfter, input logic [DW-1:0] txd,
                                 input int txDelay, input int txCut, input bit cutByReset);
        bit   bits[FW];
        int   nBits;
        bit   isReadData;
        bit   early;
        bit   misoSeen;
        logic expBit;
        bits[0] = c1;
        bits[1] = c0;
        for (int i = 0; i < DW; i++) begin
            bits[2+i] = MSB ? payload[DW-1-i] : payload[i];
        end
        nBits      = (abortAfter < 0) ? FW : abortAfter;
        isReadData = c1 && modelSeen;
        early      = 1'b0;

        mosi = 1'($urandom);
        ssN  = 1'b0;
        tick();
        checkOutput("busy_in_frame", busy, 1);
        for (int i = 0; i < nBits; i++) begin
            mosi = bits[i];
            tick();
            if (i < FW - 1 && rxValid) early = 1'b1;
        end
        checkOutput("no_early_rx_valid", early, 0);

        if (abortAfter >= 0) begin
            ssN  = 1'b1;
            mosi = 1'b0;
            tick();
            checkOutput("abort_frame_err", frameErr, 1);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_rx_valid", rxValid, 0);
            if (modelErr < 255) modelErr++;
            tick();
            checkOutput("frame_err_pulse", frameErr, 0);
            checkOutput("abort_rx_data_kept", rxData, modelRx);
            checkErrCnt();
            return;
        end

        checkOutput("rx_valid", rxValid, 1);
        modelRx = {c1, c0, payload};
        checkOutput("rx_data", rxData, modelRx);
        if (c1) modelSeen = !modelSeen;

        if (isReadData) begin
            misoSeen = 1'b0;
            for (int j = 0; j < txDelay; j++) begin
                txValid = 1'b0;
                txData  = DW'($urandom);
                tick();
                if (j == 0) checkOutput("rx_valid_pulse", rxValid, 0);
                if (miso) misoSeen = 1'b1;
            end
            checkOutput("miso_idle_wait", misoSeen, 0);
            txData  = txd;
            txValid = 1'b1;
            tick();
            txValid = 1'b0;
            txData  = DW'($urandom);
            for (int i = 0; i < DW; i++) begin
                if (i == txCut) begin
                    if (cutByReset) begin
                        rstN = 1'b0;
                        #1;
                        checkOutput("reset_miso", miso, 0);
                        checkOutput("reset_busy", busy, 0);
                        checkOutput("reset_frame_err", frameErr, 0);
                        checkOutput("reset_rx_valid", rxValid, 0);
                        checkOutput("reset_rx_data", rxData, 0);
                        ssN = 1'b1;
                        #1;
                        rstN = 1'b1;
                        modelReset();
                        tick();
                        checkOutput("no_err_after_reset", frameErr, 0);
                        checkErrCnt();
                    end else begin
                        ssN = 1'b1;
                        tick();
                        checkOutput("tx_abort_frame_err", frameErr, 1);
                        checkOutput("tx_abort_miso", miso, 0);
                        checkOutput("tx_abort_busy", busy, 0);
                        if (modelErr < 255) modelErr++;
                        tick();
                        checkOutput("tx_frame_err_pulse", frameErr, 0);
                        checkErrCnt();
                    end
                    return;
                end
                expBit = MSB ? txd[DW-1-i] : txd[i];
                checkOutput($sformatf("miso_bit%0d", i), miso, expBit);
                tick();
            end
            checkOutput("miso_after_tx", miso, 0);
            checkOutput("busy_hold", busy, 1);
        end else begin
            misoSeen = 1'b0;
            txValid  = 1'b1;
            txData   = txd;
            tick();
            checkOutput("rx_valid_pulse", rxValid, 0);
            if (miso) misoSeen = 1'b1;
            for (int j = 0; j < DW; j++) begin
                tick();
                if (miso) misoSeen = 1'b1;
            end
            txValid = 1'b0;
            checkOutput("miso_quiet", misoSeen, 0);
            checkOutput("busy_hold", busy, 1);
        end

        ssN = 1'b1;
        tick();
        checkOutput("end_busy", busy, 0);
        checkOutput("end_no_frame_err", frameErr, 0);
        checkErrCnt();
    endtask

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit   early16;
        logic [15:0] pay16;
        bit   rbits[FW];

        vecs[0]  = '{1'b0, 1'b0, 8'hA5, -1, 8'h00, -1, 1'b0, 10'h0A5};
        vecs[1]  = '{1'b1, 1'b0, 8'h3C, -1, 8'hFF, -1, 1'b0, 10'h23C};
        vecs[2]  = '{1'b1, 1'b1, 8'h00, -1, 8'hC3, -1, 1'b0, 10'h300};
        vecs[3]  = '{1'b0, 1'b1, 8'h5A,  5, 8'h00, -1, 1'b0, 10'h300};
        vecs[4]  = '{1'b1, 1'b0, 8'h81, -1, 8'h77, -1, 1'b0, 10'h281};
        vecs[5]  = '{1'b1, 1'b1, 8'h42,  3, 8'h00, -1, 1'b0, 10'h281};
        vecs[6]  = '{1'b1, 1'b0, 8'h7E, -1, 8'h5A, -1, 1'b0, 10'h27E};
        vecs[7]  = '{1'b0, 1'b1, 8'hFF, -1, 8'hAA, -1, 1'b0, 10'h1FF};
        vecs[8]  = '{1'b0, 1'b0, 8'h00,  0, 8'h00, -1, 1'b0, 10'h1FF};
        vecs[9]  = '{1'b0, 1'b1, 8'h12,  9, 8'h00, -1, 1'b0, 10'h1FF};
        vecs[10] = '{1'b1, 1'b0, 8'h11, -1, 8'h00, -1, 1'b0, 10'h211};
        vecs[11] = '{1'b1, 1'b1, 8'h22, -1, 8'h96,  3, 1'b0, 10'h322};
        vecs[12] = '{1'b1, 1'b1, 8'h33, -1, 8'hE7, -1, 1'b0, 10'h333};
        vecs[13] = '{1'b1, 1'b0, 8'h44, -1, 8'hF0,  4, 1'b1, 10'h000};

        rstN      = 1'b0;
        ssN       = 1'b1;
        mosi      = 1'b0;
        txData    = '0;
        txValid   = 1'b0;
        ssN16     = 1'b1;
        mosi16    = 1'b0;
        txData16  = '0;
        txValid16 = 1'b0;
        modelReset();

        #12;
        checkOutput("reset_rx_data", rxData, 0);
        checkOutput("reset_rx_valid", rxValid, 0);
        checkOutput("reset_miso", miso, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_frame_err", frameErr, 0);
        checkErrCnt();
        rstN = 1'b1;
        tick();
        checkOutput("idle_busy", busy, 0);

        for (int k = 0; k < 14; k++) begin
            applyStimulus(vecs[k].c1, vecs[k].c0, vecs[k].payload, vecs[k].abortAfter,
                          vecs[k].txd, 1 + (k % 3), vecs[k].txCut, vecs[k].cutRst);
            checkOutput($sformatf("vec%0d_rx_data", k), rxData, vecs[k].expRx);
        end

        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'($urandom), 1'($urandom), DW'($urandom),
                          ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FW - 1)) : -1,
                          DW'($urandom), int'($urandom_range(1, 3)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW - 2)) : -1,
                          ($urandom_range(0, 3) == 0));
        end

        // Reset during the receive phase of a read-data frame: the pending
        // read address must be forgotten.
        applyStimulus(1'b1, 1'b0, 8'h66, -1, 8'h00, 1, -1, 1'b0);
        if (modelSeen == 1'b0) begin
            applyStimulus(1'b1, 1'b0, 8'h67, -1, 8'h00, 1, -1, 1'b0);
        end
        rbits[0] = 1'b1;
        rbits[1] = 1'b1;
        for (int i = 2; i < FW; i++) rbits[i] = 1'($urandom);
        ssN = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            mosi = rbits[i];
            tick();
        end
        rstN = 1'b0;
        #1;
        checkOutput("midrx_reset_busy", busy, 0);
        checkOutput("midrx_reset_miso", miso, 0);
        checkOutput("midrx_reset_rx_valid", rxValid, 0);
        ssN = 1'b1;
        #1;
        rstN = 1'b1;
        modelReset();
        tick();
        checkOutput("midrx_reset_no_err", frameErr, 0);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h55, -1, 8'hAA, 1, -1, 1'b0);
        checkOutput("after_reset_routed_read_add", modelSeen, 1);

        // 16-bit LSB-first write frame.
        pay16   = 16'h1234;
        early16 = 1'b0;
        ssN16   = 1'b0;
        tick();
        mosi16 = 1'b0;
        tick();
        mosi16 = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (rxValid16) early16 = 1'b1;
            mosi16 = pay16[i];
            tick();
        end
        checkOutput("w16_no_early_valid", early16, 0);
        checkOutput("w16_rx_valid", rxValid16, 1);
        checkOutput("w16_rx_data", rxData16, 18'h01234);
        tick();
        checkOutput("w16_rx_valid_pulse", rxValid16, 0);
        checkOutput("w16_miso", miso16, 0);
        ssN16 = 1'b1;
        tick();
        checkOutput("w16_end_busy", busy16, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per frame; legal range 4..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = MSB-first shift order on mosi and miso; 0 = LSB-first.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ss_n  input  1  slave select, active low; synchronous to clk.
REQ-006 SHALL have port mosi  input  1  serial data in, sampled on clk.
REQ-007 SHALL have port miso  output  1  serial data out, registered.
REQ-008 SHALL have port rx_data  output  DATA_WIDTH+2  received frame: 2 command bits in MSBs, payload below.
REQ-009 SHALL have port rx_valid  output  1  one-cycle pulse; rx_data is valid.
REQ-010 SHALL have port tx_data  input  DATA_WIDTH  read data to return.
REQ-011 SHALL have port tx_valid  input  1  tx_data valid; sampled only in READ_DATA while awaiting it.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on aborted frame.

Function
REQ-014 SHALL implement states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-015 SHALL go IDLE->CHK_CMD on the first edge with ss_n low; no bit is sampled on that edge.
REQ-016 In CHK_CMD, SHALL sample mosi as command bit 1 (rx_data[DATA_WIDTH+1]); mosi=0 -> WRITE; mosi=1 with rd_addr_seen=0 -> READ_ADD; mosi=1 with rd_addr_seen=1 -> READ_DATA.
REQ-017 In WRITE/READ_ADD/READ_DATA, SHALL shift in the remaining DATA_WIDTH+1 bits, one per clk, in the order set by MSB_FIRST for the payload; command bits are always received first.
REQ-018 The cycle after the last bit is sampled, SHALL update rx_data and assert rx_valid for exactly one cycle.
REQ-019 Completing a READ_ADD frame SHALL set internal rd_addr_seen; completing a READ_DATA frame SHALL clear it.
REQ-020 After rx_valid in READ_DATA, SHALL wait for tx_valid, then latch tx_data on that edge.
REQ-021 On the next DATA_WIDTH cycles, SHALL drive miso with the latched bits in MSB_FIRST order, one bit per cycle; at all other times miso = 0.
REQ-022 After the last miso bit or rx_valid in WRITE/READ_ADD, SHALL hold its state with miso = 0 until ss_n rises.
REQ-023 ss_n high in any non-IDLE state SHALL force IDLE on that edge and discard any partial frame (no rx_valid, rx_data unchanged).
REQ-024 If the abort occurs before rx_valid, or while miso bits remain, SHALL pulse frame_err for one cycle; rd_addr_seen SHALL be unchanged.
REQ-025 Changes to tx_valid/tx_data outside the wait window of REQ-020 SHALL have no effect.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, rd_addr_seen 0, rx_data 0, rx_valid 0, miso 0, busy 0, frame_err 0, all counters and shift registers 0.
REQ-027 Reset asserted mid-frame SHALL abort it with no rx_valid or frame_err pulse.

Configuration
REQ-028 With macro SPI_SLAVE_ERR_CNT_EN defined, SHALL add output port err_cnt (8 bits): it counts frame_err pulses, saturates at 255 and is reset to 0.
REQ-029 Without SPI_SLAVE_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (DATA_WIDTH=8, MSB_FIRST=1 unless stated)
REQ-030 Write frame: ss_n low, mosi 0,0,0xA5 bits -> rx_valid pulse 11 clks after ss_n fall, rx_data=0x0A5, miso stays 0.
REQ-031 Read pair: read-address frame 1,0,0x3C -> rx_data=0x23C; then read-data frame 1,1,0x00 -> rx_data=0x300; tx_valid with tx_data=0xC3 -> miso shows 1,1,0,0,0,0,1,1 on the next 8 cycles.
REQ-032 Abort: ss_n high after 5 bits -> IDLE next edge, frame_err one pulse, no rx_valid; err_cnt=1 when the macro is defined.
REQ-033 Reset mid-read-data shift -> miso=0, busy=0 immediately; next read frame is routed to READ_ADD.
REQ-034 DATA_WIDTH=16, MSB_FIRST=0: write frame with payload 0x1234 sent LSB-first -> rx_data=0x01234 after 19 clks.
